// File: rtl/lsu_mem_initiator_if.sv
// Core-side request/response and data-memory port bundle for the load/store initiator.
// master = the initiator itself, slave = core + memory environment.
interface lsu_mem_initiator_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              is_store;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              busy;

  modport master (
    input  req_valid, is_store, funct3, addr, wdata, mem_ack, mem_rdata,
    output req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    output req_valid, is_store, funct3, addr, wdata, mem_ack, mem_rdata,
    input  req_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
           resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/lsu_mem_initiator.sv
// RISC-V load/store initiator: one access at a time, resp 2+wait cycles after accept (1 on error).
// Backpressure: req_ready only in IDLE; mem_req held until mem_ack or TIMEOUT cycles elapse.
module lsu_mem_initiator #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  lsu_mem_initiator_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam int               CNT_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t            r_state,       w_state_nxt;
  logic              r_is_store,    w_is_store_nxt;
  logic [2:0]        r_funct3,      w_funct3_nxt;
  logic [1:0]        r_addr_lo,     w_addr_lo_nxt;
  logic [CNT_W-1:0]  r_cnt,         w_cnt_nxt;
  logic              r_req_ready,   w_req_ready_nxt;
  logic              r_busy,        w_busy_nxt;
  logic              r_mem_req,     w_mem_req_nxt;
  logic              r_mem_we,      w_mem_we_nxt;
  logic [ADDR_W-3:0] r_mem_addr,    w_mem_addr_nxt;
  logic [3:0]        r_mem_wstrb,   w_mem_wstrb_nxt;
  logic [31:0]       r_mem_wdata,   w_mem_wdata_nxt;
  logic              r_resp_valid,  w_resp_valid_nxt;
  logic [31:0]       r_resp_rdata,  w_resp_rdata_nxt;
  logic              r_resp_err,    w_resp_err_nxt;

  // Request classification and store lane placement, straight from the core inputs
  logic        w_f3_illegal;
  logic        w_misalign;
  logic [3:0]  w_st_strb;
  logic [31:0] w_st_data;

  always_comb begin
    w_f3_illegal = bus.is_store ? (bus.funct3 > 3'd2)
                                : ((bus.funct3 == 3'd3) || (bus.funct3[2:1] == 2'b11));
    w_misalign   = ((bus.funct3[1:0] == 2'b01) && bus.addr[0]) ||
                   ((bus.funct3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    w_st_strb    = 4'b1111;
    w_st_data    = bus.wdata;
    case (bus.funct3[1:0])
      2'b00: begin
        w_st_strb = 4'b0001 << bus.addr[1:0];
        w_st_data = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        w_st_strb = 4'b0011 << {bus.addr[1], 1'b0};
        w_st_data = {2{bus.wdata[15:0]}};
      end
      default: begin
        w_st_strb = 4'b1111;
        w_st_data = bus.wdata;
      end
    endcase
  end

  // Lane shift brings the addressed byte/halfword to bit 0; words are aligned so shift is 0
  logic [31:0] w_ld_shift;
  logic [31:0] w_ld_data;

  always_comb begin
    w_ld_shift = bus.mem_rdata >> {r_addr_lo, 3'b000};
    case (r_funct3)
      3'd0:    w_ld_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      3'd1:    w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'd4:    w_ld_data = {24'd0, w_ld_shift[7:0]};
      3'd5:    w_ld_data = {16'd0, w_ld_shift[15:0]};
      default: w_ld_data = w_ld_shift;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_is_store_nxt   = r_is_store;
    w_funct3_nxt     = r_funct3;
    w_addr_lo_nxt    = r_addr_lo;
    w_cnt_nxt        = '0;
    w_mem_req_nxt    = r_mem_req;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wstrb_nxt  = r_mem_wstrb;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_resp_valid_nxt = 1'b0;
    w_resp_rdata_nxt = r_resp_rdata;
    w_resp_err_nxt   = r_resp_err;

    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_is_store_nxt = bus.is_store;
          w_funct3_nxt   = bus.funct3;
          w_addr_lo_nxt  = bus.addr[1:0];
          if (w_f3_illegal || w_misalign) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_err_nxt   = 1'b1;
            w_resp_rdata_nxt = '0;
          end else begin
            w_state_nxt     = S_ACCESS;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = bus.is_store;
            w_mem_addr_nxt  = bus.addr[ADDR_W-1:2];
            w_mem_wstrb_nxt = bus.is_store ? w_st_strb : 4'b0000;
            w_mem_wdata_nxt = bus.is_store ? w_st_data : 32'd0;
          end
        end
      end

      S_ACCESS: begin
        // An ack in the final allowed cycle still counts as success
        if (bus.mem_ack || (r_cnt == CNT_LAST)) begin
          w_state_nxt      = S_RESP;
          w_mem_req_nxt    = 1'b0;
          w_mem_we_nxt     = 1'b0;
          w_mem_wstrb_nxt  = 4'b0000;
          w_mem_wdata_nxt  = 32'd0;
          w_resp_valid_nxt = 1'b1;
          w_resp_err_nxt   = !bus.mem_ack;
          w_resp_rdata_nxt = (bus.mem_ack && !r_is_store) ? w_ld_data : 32'd0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      S_RESP: begin
        w_state_nxt      = S_IDLE;
        w_resp_rdata_nxt = '0;
        w_resp_err_nxt   = 1'b0;
      end

      default: begin
        w_state_nxt   = S_IDLE;
        w_mem_req_nxt = 1'b0;
      end
    endcase

    w_req_ready_nxt = (w_state_nxt == S_IDLE);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_is_store   <= 1'b0;
      r_funct3     <= 3'd0;
      r_addr_lo    <= 2'd0;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wstrb  <= 4'b0000;
      r_mem_wdata  <= 32'd0;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= 32'd0;
      r_resp_err   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_is_store   <= w_is_store_nxt;
      r_funct3     <= w_funct3_nxt;
      r_addr_lo    <= w_addr_lo_nxt;
      r_cnt        <= w_cnt_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_busy       <= w_busy_nxt;
      r_mem_req    <= w_mem_req_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wstrb  <= w_mem_wstrb_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_rdata <= w_resp_rdata_nxt;
      r_resp_err   <= w_resp_err_nxt;
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.busy       = r_busy;
  assign bus.mem_req    = r_mem_req;
  assign bus.mem_we     = r_mem_we;
  assign bus.mem_addr   = r_mem_addr;
  assign bus.mem_wstrb  = r_mem_wstrb;
  assign bus.mem_wdata  = r_mem_wdata;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_rdata = r_resp_rdata;
  assign bus.resp_err   = r_resp_err;

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Bench for lsu_mem_initiator: vector table driven per transaction, responses checked
// against a scoreboard queue, plus reset-during-access sequence.
module tb_lsu_mem_initiator;

  localparam int ADDR_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int NO_ACK  = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  lsu_mem_initiator_if #(.ADDR_W(ADDR_W)) bus ();

  lsu_mem_initiator #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    bit          st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_dly;
    bit          exp_err;
    logic [31:0] exp_rdata;
    bit          exp_we;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    bit          chk_wdata;
    int          exp_cyc;
  } vec_t;

  typedef struct {
    string       name;
    bit          err;
    logic [31:0] rdata;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input string name, input bit st, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int ack_dly,
                              input bit exp_err, input logic [31:0] exp_rdata,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                              input bit chk_wdata, input int exp_cyc);
    vec_t v;
    v.name = name; v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.rdata = rdata; v.ack_dly = ack_dly; v.exp_err = exp_err;
    v.exp_rdata = exp_rdata; v.exp_we = st; v.exp_strb = exp_strb;
    v.exp_wdata = exp_wdata; v.chk_wdata = chk_wdata; v.exp_cyc = exp_cyc;
    return v;
  endfunction

  // Response monitor: every resp_valid pulse must match the oldest expected entry
  always @(negedge clk) begin
    if (!reset && bus.resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1, expected no response at %0t", $time);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk({e.name, ".resp_err"},   32'(bus.resp_err), 32'(e.err));
        chk({e.name, ".resp_rdata"}, bus.resp_rdata,    e.rdata);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int   cyc;
    exp_t e;
    @(negedge clk);
    chk({v.name, ".req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.is_store  = v.st;
    bus.funct3    = v.f3;
    bus.addr      = v.addr;
    bus.wdata     = v.wdata;
    e.name = v.name; e.err = v.exp_err; e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.addr      = $urandom;
    bus.wdata     = $urandom;
    bus.funct3    = 3'($urandom_range(0, 7));
    cyc = 0;
    while (bus.resp_valid !== 1'b1 && cyc < 64) begin
      chk({v.name, ".mem_req"},   32'(bus.mem_req),   32'd1);
      chk({v.name, ".mem_we"},    32'(bus.mem_we),    32'(v.exp_we));
      chk({v.name, ".mem_addr"},  32'(bus.mem_addr),  v.addr >> 2);
      chk({v.name, ".mem_wstrb"}, 32'(bus.mem_wstrb), 32'(v.exp_strb));
      chk({v.name, ".busy"},      32'(bus.busy),      32'd1);
      if (v.chk_wdata) chk({v.name, ".mem_wdata"}, bus.mem_wdata, v.exp_wdata);
      bus.mem_ack   = (cyc == v.ack_dly);
      bus.mem_rdata = (cyc == v.ack_dly) ? v.rdata : $urandom;
      cyc++;
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = $urandom;
    end
    chk({v.name, ".access_cycles"}, 32'(cyc), 32'(v.exp_cyc));
    chk({v.name, ".resp_valid"},    32'(bus.resp_valid), 32'd1);
    chk({v.name, ".mem_req_resp"},  32'(bus.mem_req),    32'd0);
    chk({v.name, ".busy_resp"},     32'(bus.busy),       32'd1);
    chk({v.name, ".req_ready_resp"},32'(bus.req_ready),  32'd0);
    @(negedge clk);
    chk({v.name, ".resp_pulse"},    32'(bus.resp_valid), 32'd0);
    chk({v.name, ".req_ready_idle"},32'(bus.req_ready),  32'd1);
    chk({v.name, ".busy_idle"},     32'(bus.busy),       32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            name     st f3 addr   wdata         rdata         dly     err rdata_exp     strb  wdata_exp     cw cyc
    vecs.push_back(mk("sb13",   1, 0, 32'h13, 32'h000000A5, 32'h0,        0,      0, 32'h0,        4'h8, 32'hA5A5A5A5, 1, 1));
    vecs.push_back(mk("lb2",    0, 0, 32'h02, 32'h0,        32'h00800000, 0,      0, 32'hFFFFFF80, 4'h0, 32'h0,        0, 1));
    vecs.push_back(mk("lbu2",   0, 4, 32'h02, 32'h0,        32'h00800000, 0,      0, 32'h00000080, 4'h0, 32'h0,        0, 1));
    vecs.push_back(mk("lhu2",   0, 5, 32'h02, 32'h0,        32'h00800000, 0,      0, 32'h00000080, 4'h0, 32'h0,        0, 1));
    vecs.push_back(mk("lh0",    0, 1, 32'h00, 32'h0,        32'h0000F00D, 1,      0, 32'hFFFFF00D, 4'h0, 32'h0,        0, 2));
    vecs.push_back(mk("lh2",    0, 1, 32'h02, 32'h0,        32'h80010000, 0,      0, 32'hFFFF8001, 4'h0, 32'h0,        0, 1));
    vecs.push_back(mk("lb1",    0, 0, 32'h01, 32'h0,        32'h00007F00, 2,      0, 32'h0000007F, 4'h0, 32'h0,        0, 3));
    vecs.push_back(mk("lw_mis", 0, 2, 32'h06, 32'h0,        32'h0,        0,      1, 32'h0,        4'h0, 32'h0,        0, 0));
    vecs.push_back(mk("ld_f3",  0, 3, 32'h00, 32'h0,        32'h0,        0,      1, 32'h0,        4'h0, 32'h0,        0, 0));
    vecs.push_back(mk("ld_f7",  0, 7, 32'h04, 32'h0,        32'h0,        0,      1, 32'h0,        4'h0, 32'h0,        0, 0));
    vecs.push_back(mk("sh_mis", 1, 1, 32'h21, 32'h1234BEEF, 32'h0,        0,      1, 32'h0,        4'h0, 32'h0,        0, 0));
    vecs.push_back(mk("st_f4",  1, 4, 32'h20, 32'h1234BEEF, 32'h0,        0,      1, 32'h0,        4'h0, 32'h0,        0, 0));
    vecs.push_back(mk("sw_tmo", 1, 2, 32'h40, 32'hCAFEF00D, 32'h0,        NO_ACK, 1, 32'h0,        4'hF, 32'hCAFEF00D, 1, TIMEOUT));
    vecs.push_back(mk("lw8",    0, 2, 32'h08, 32'h0,        32'hDEADBEEF, 3,      0, 32'hDEADBEEF, 4'h0, 32'h0,        0, 4));
    vecs.push_back(mk("sh22",   1, 1, 32'h22, 32'h1234BEEF, 32'hFFFFFFFF, 1,      0, 32'h0,        4'hC, 32'hBEEFBEEF, 1, 2));
    vecs.push_back(mk("sb0",    1, 0, 32'h00, 32'h0000005A, 32'h0,        0,      0, 32'h0,        4'h1, 32'h5A5A5A5A, 1, 1));
    vecs.push_back(mk("lw_edge",0, 2, 32'h0C, 32'h0,        32'h12345678, TIMEOUT-1, 0, 32'h12345678, 4'h0, 32'h0,   0, TIMEOUT));

    bus.req_valid = 1'b0;
    bus.is_store  = 1'b0;
    bus.funct3    = 3'd0;
    bus.addr      = '0;
    bus.wdata     = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst.req_ready",  32'(bus.req_ready),  32'd1);
    chk("rst.mem_req",    32'(bus.mem_req),    32'd0);
    chk("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst.busy",       32'(bus.busy),       32'd0);
    chk("rst.resp_err",   32'(bus.resp_err),   32'd0);
    chk("rst.mem_wstrb",  32'(bus.mem_wstrb),  32'd0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

    // Reset during ACCESS: request dropped, no response, then a normal load
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.is_store  = 1'b0;
    bus.funct3    = 3'd2;
    bus.addr      = 32'h20;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_rst.mem_req_before", 32'(bus.mem_req), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst.mem_req",    32'(bus.mem_req),    32'd0);
    chk("mid_rst.resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst.req_ready",  32'(bus.req_ready),  32'd1);
    chk("mid_rst.busy",       32'(bus.busy),       32'd0);
    repeat (TIMEOUT + 4) @(negedge clk);
    chk("mid_rst.idle_after", 32'(bus.mem_req),    32'd0);
    run_vec(mk("lw_after_rst", 0, 2, 32'h24, 32'h0, 32'h0BADF00D, 0, 0, 32'h0BADF00D, 4'h0, 32'h0, 0, 1));

    repeat (2) @(negedge clk);
    chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
